ir_cmd_scheduler: RTL and testbench



---
 rtl/ir_cmd_scheduler.sv | 173 +++++++++++++++++
 tb/tb_ir_cmd_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ir_cmd_scheduler.sv
// NEC IR receive sequencer: sample-tick prescaler, key hold/release tracking and a
// press/auto-repeat command FIFO. Define IR_AUTOREPEAT_EN to build the auto-repeat path.
module ir_cmd_scheduler #(
  parameter int CLK_DIV       = 28125,
  parameter int RELEASE_TICKS = 256,
  parameter int REPEAT_DELAY  = 800,
  parameter int REPEAT_RATE   = 178,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       ir_in,
  output logic       sample_tick,
  input  logic       dec_valid,
  input  logic [7:0] dec_value,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_data,
  output logic       cmd_repeat,
  output logic       key_held,
  output logic       overflow
);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int REL_W = $clog2(RELEASE_TICKS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
`ifdef IR_AUTOREPEAT_EN
  localparam int DLY_W  = $clog2(REPEAT_DELAY + 1);
  localparam int RATE_W = $clog2(REPEAT_RATE + 1);
  localparam int RPT_W  = (DLY_W > RATE_W) ? DLY_W : RATE_W;
  localparam int ENT_W  = 9;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REPEAT} state_t;
`else
  localparam int ENT_W  = 8;
  typedef enum logic {S_IDLE, S_WAIT} state_t;
`endif

  if (CLK_DIV < 2 || RELEASE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("ir_cmd_scheduler: illegal parameter set");
  end

  logic             ir_meta_q, ir_sync_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [REL_W-1:0] rel_q, rel_d;
  logic             rel_fire, rel_clr;
  state_t           state_q, state_d;
  logic [7:0]       key_q, key_d;
`ifdef IR_AUTOREPEAT_EN
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif
  logic             push, pop, full, push_ok;
  logic [ENT_W-1:0] push_data, head;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             ovf_q, ovf_d;

  // Prescaler freezes while disabled so ticks resume on the same phase.
  always_comb begin
    sample_tick = enable && (div_q == DIV_W'(CLK_DIV - 1));
    div_d       = div_q;
    if (enable) div_d = sample_tick ? '0 : div_q + DIV_W'(1);
  end

  always_comb begin
    rel_fire = sample_tick && ir_sync_q && (rel_q == REL_W'(RELEASE_TICKS - 1));
    rel_d    = rel_q;
    if (sample_tick) begin
      if (!ir_sync_q)                        rel_d = '0;
      else if (rel_q != REL_W'(RELEASE_TICKS)) rel_d = rel_q + REL_W'(1);
    end
    if (rel_clr) rel_d = '0;
  end

  // Priority in a held state: new code, then release, then repeat expiry, then tick.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    push      = 1'b0;
    push_data = '0;
    rel_clr   = 1'b0;
`ifdef IR_AUTOREPEAT_EN
    rpt_d     = rpt_q;
`endif
    if (!enable) begin
      state_d = S_IDLE;
    end else if (dec_valid && (state_q == S_IDLE || dec_value != key_q)) begin
      push      = 1'b1;
      push_data = ENT_W'({1'b0, dec_value});
      key_d     = dec_value;
      rel_clr   = rel_fire;
      state_d   = S_WAIT;
`ifdef IR_AUTOREPEAT_EN
      rpt_d     = '0;
`endif
    end else if (state_q != S_IDLE) begin
      if (rel_fire) begin
        state_d = S_IDLE;
`ifdef IR_AUTOREPEAT_EN
      end else if ((state_q == S_WAIT   && rpt_q == RPT_W'(REPEAT_DELAY)) ||
                   (state_q == S_REPEAT && rpt_q == RPT_W'(REPEAT_RATE))) begin
        push      = 1'b1;
        push_data = {1'b1, key_q};
        rpt_d     = '0;
        state_d   = S_REPEAT;
      end else if (sample_tick) begin
        rpt_d = rpt_q + RPT_W'(1);
`endif
      end
    end
  end

  // Extra pointer bit separates full from empty.
  always_comb begin
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop     = cmd_valid && cmd_ready;
    push_ok = push && (!full || pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d = wr_q + (AW+1)'(1);
    end
    if (push && !push_ok) ovf_d = 1'b1;
    if (pop) rd_d = rd_q + (AW+1)'(1);
  end

  assign head      = mem_q[rd_q[AW-1:0]];
  assign cmd_valid = (wr_q != rd_q);
  assign cmd_data  = cmd_valid ? head[7:0] : 8'h00;
`ifdef IR_AUTOREPEAT_EN
  assign cmd_repeat = cmd_valid && head[8];
`else
  assign cmd_repeat = 1'b0;
`endif
  assign key_held  = (state_q != S_IDLE);
  assign overflow  = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_meta_q <= 1'b1;
      ir_sync_q <= 1'b1;
      div_q     <= '0;
      rel_q     <= '0;
      state_q   <= S_IDLE;
      key_q     <= '0;
`ifdef IR_AUTOREPEAT_EN
      rpt_q     <= '0;
`endif
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ir_meta_q <= ir_in;
      ir_sync_q <= ir_meta_q;
      div_q     <= div_d;
      rel_q     <= rel_d;
      state_q   <= state_d;
      key_q     <= key_d;
`ifdef IR_AUTOREPEAT_EN
      rpt_q     <= rpt_d;
`endif
      mem_q     <= mem_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      ovf_q     <= ovf_d;
    end
  end
endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Self-checking bench for ir_cmd_scheduler: directed scenarios plus random traffic,
// every output compared each cycle against an event-level reference model.
module tb_ir_cmd_scheduler;
  localparam int CLK_DIV = 4, RELEASE_TICKS = 8, REPEAT_DELAY = 6, REPEAT_RATE = 3, FIFO_DEPTH = 4;
`ifdef IR_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1, enable = 1'b1, ir_in = 1'b1, dec_valid = 1'b0, cmd_ready = 1'b1;
  logic [7:0] dec_value = 8'h00;
  logic       sample_tick, cmd_valid, cmd_repeat, key_held, overflow;
  logic [7:0] cmd_data;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  ir_cmd_scheduler #(.CLK_DIV(CLK_DIV), .RELEASE_TICKS(RELEASE_TICKS), .REPEAT_DELAY(REPEAT_DELAY),
                     .REPEAT_RATE(REPEAT_RATE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ir_in(ir_in), .sample_tick(sample_tick),
    .dec_valid(dec_valid), .dec_value(dec_value), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_repeat(cmd_repeat), .key_held(key_held), .overflow(overflow));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: tick phase, line history, held key with ticks since its last command.
  int         pcnt, rel_cnt, since, gap;
  bit         s1, s2, held, pend, ovf, armed = 1'b0;
  logic [7:0] key;
  logic [8:0] fq[$];
  int         fresh_seen = 0, rpt_seen = 0;

  always @(posedge clk) begin
    if (reset) begin
      pcnt = 0; rel_cnt = 0; since = 0; gap = REPEAT_DELAY;
      s1 = 1; s2 = 1; held = 0; pend = 0; ovf = 0; key = 0;
      fq.delete();
      armed = 1'b1;
    end else begin
      bit tick, rel, pop, have;
      logic [8:0] ent;
      tick = enable && pcnt == CLK_DIV - 1;
      rel  = tick && s2 && rel_cnt == RELEASE_TICKS - 1;
      pop  = fq.size() > 0 && cmd_ready;
      have = 0; ent = '0;
      if (tick) rel_cnt = !s2 ? 0 : (rel_cnt < RELEASE_TICKS ? rel_cnt + 1 : rel_cnt);
      if (!enable) begin
        held = 0; pend = 0;
      end else if (dec_valid && (!held || dec_value != key)) begin
        have = 1; ent = {1'b0, dec_value};
        held = 1; key = dec_value; since = 0; gap = REPEAT_DELAY; pend = 0;
        if (rel) rel_cnt = 0;
      end else if (held && rel) begin
        held = 0; pend = 0;
      end else if (AR && held && pend) begin
        have = 1; ent = {1'b1, key}; pend = 0; since = 0; gap = REPEAT_RATE;
      end else if (AR && held && tick) begin
        since++;
        if (since == gap) pend = 1;
      end
      if (pop) void'(fq.pop_front());
      if (have) begin
        if (fq.size() < FIFO_DEPTH) fq.push_back(ent);
        else ovf = 1;
      end
      if (enable) pcnt = (pcnt + 1) % CLK_DIV;
      s2 = s1; s1 = ir_in;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("sample_tick", sample_tick, enable && pcnt == CLK_DIV - 1);
      chk("cmd_valid", cmd_valid, fq.size() > 0);
      chk("cmd_data", cmd_data, fq.size() > 0 ? fq[0][7:0] : 8'h00);
      chk("cmd_repeat", cmd_repeat, fq.size() > 0 ? fq[0][8] : 1'b0);
      chk("key_held", key_held, held);
      chk("overflow", overflow, ovf);
      if (cmd_valid && cmd_ready) begin
        if (cmd_repeat) rpt_seen++;
        else fresh_seen++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    reset = 1'b1; dec_valid = 1'b0; cmd_ready = 1'b1; enable = 1'b1; ir_in = 1'b1;
    cyc(2);
    reset = 1'b0;
    fresh_seen = 0; rpt_seen = 0;
  endtask

  task automatic press(input logic [7:0] v);
    dec_valid = 1'b1; dec_value = v; cyc(1); dec_valid = 1'b0;
  endtask

  initial begin
    // Reset state and free-running tick
    do_reset();
    cyc(12);
    chk("no_press_cmds", fresh_seen + rpt_seen, 0);

    // Single press then line idle high until release
    do_reset();
    ir_in = 1'b0; cyc(5);
    ir_in = 1'b1; press(8'h45);
    cyc(RELEASE_TICKS * CLK_DIV + 8);
    chk("single_fresh", fresh_seen, 1);
    chk("single_released", key_held, 1'b0);

    // Held key with periodic low samples: repeats at ticks 6,9,12,15,18
    do_reset();
    for (int c = 0; c < 84; c++) begin
      ir_in = ((c / 4) % 4 == 1) ? 1'b0 : 1'b1;
      dec_valid = (c == 0); dec_value = 8'h45;
      cyc(1);
    end
    dec_valid = 1'b0;
    chk("hold_fresh", fresh_seen, 1);
    chk("hold_repeats", rpt_seen, AR ? 5 : 0);

    // New code while repeating, then the same code again
    fresh_seen = 0; rpt_seen = 0;
    for (int c = 84; c < 140; c++) begin
      ir_in = ((c / 4) % 4 == 1) ? 1'b0 : 1'b1;
      dec_valid = (c == 86 || c == 110); dec_value = 8'h16;
      cyc(1);
    end
    dec_valid = 1'b0;
    chk("newcode_fresh", fresh_seen, 1);
    chk("newcode_held", key_held, 1'b1);

    // Fill FIFO with consumer stalled, overflow on fifth, then drain in order
    do_reset();
    ir_in = 1'b0; cmd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin press(8'(i)); cyc(1); end
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_valid", cmd_valid, 1'b1);
    cmd_ready = 1'b1; cyc(4); cmd_ready = 1'b0;
    chk("drain_count", fresh_seen, 4);
    cyc(2); cmd_ready = 1'b1;

    // Random traffic including enable drops and mid-run resets
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      dec_valid = ($urandom_range(0, 14) == 0);
      dec_value = 8'h10 + 8'($urandom_range(0, 2));
      if ($urandom_range(0, 11) == 0) ir_in = ~ir_in;
      cmd_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      reset = ($urandom_range(0, 399) == 0);
      cyc(1);
    end
    reset = 1'b0; dec_valid = 1'b0; enable = 1'b1; cmd_ready = 1'b1;
    cyc(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
